// File: rtl/latch_arb_pkg.sv
// Shared encodings for the latch arbiter: FSM states,
// op codes, owner tags and the registered output bundle.
package latch_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_HI = 3'd1,
    S_WR_LO = 3'd2,
    S_RD    = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  localparam logic [2:0] OP_LATCH  = 3'd0;
  localparam logic [2:0] OP_LATCH3 = 3'd1;
  localparam logic [2:0] OP_RD1    = 3'd2;
  localparam logic [2:0] OP_RD3    = 3'd3;
  localparam logic [2:0] OP_RD2    = 3'd4;

  typedef struct packed {
    logic gnt_a;
    logic gnt_b;
    logic done_a;
    logic done_b;
    logic err;
    logic latch;
    logic latch3;
    logic oe1;
    logic oe2;
    logic oe3;
    logic busy;
  } out_t;

  function automatic logic op_is_wr(
    input logic [2:0] op
  );
    return (op == OP_LATCH) ||
           (op == OP_LATCH3);
  endfunction

  function automatic logic op_is_rd(
    input logic [2:0] op
  );
    return (op == OP_RD1) ||
           (op == OP_RD3) ||
           (op == OP_RD2);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from req,
// priority pointer moves only when the grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_b_q;
  logic prio_b_d;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = prio_b_q ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  // after granting A, B gets priority and vice versa
  always_comb begin
    prio_b_d = prio_b_q;
    if (advance && (|gnt)) begin
      prio_b_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

endmodule

// File: rtl/latch_arbiter.sv
// Arbitrates two requesters onto a shared latch block,
// sequencing write/read strobes with fully registered outputs.
import latch_arb_pkg::*;

module latch_arbiter #(
  parameter int unsigned RD_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       reqA,
  input  logic       reqB,
  input  logic [2:0] opA,
  input  logic [2:0] opB,
  output logic       gntA,
  output logic       gntB,
  output logic       doneA,
  output logic       doneB,
  output logic       err,
  output logic       latch,
  output logic       latch3,
  output logic       oe1,
  output logic       oe2,
  output logic       oe3,
  output logic       busy
);

  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n;

  state_e     state_q;
  state_e     state_d;
  owner_e     owner_q;
  owner_e     owner_d;
  logic [2:0] op_q;
  logic [2:0] op_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  out_t       out_q;
  out_t       out_d;

  logic       done_d;
  logic       advance;
  logic [1:0] arb_req;
  logic [1:0] arb_gnt;

  // assert immediately, release on a clean edge
  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n   = rst_sync_q[1];
  assign arb_req = {reqB, reqA};

  rr_arb2 u_rr (
    .clk     (CLK),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (advance),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|arb_gnt) begin
          advance = 1'b1;
          owner_d = arb_gnt[1] ? OWN_B : OWN_A;
          op_d    = arb_gnt[1] ? opB : opA;
          unique case (1'b1)
            op_is_wr(op_d): state_d = S_WR_HI;
            op_is_rd(op_d): begin
              state_d = S_RD;
              cnt_d   = RD_LOAD;
            end
            default:        state_d = S_ERR;
          endcase
        end
      end
      S_WR_HI: state_d = S_WR_LO;
      S_WR_LO: state_d = S_IDLE;
      S_RD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decoded from next state so they register alongside it
  always_comb begin
    out_d  = '0;
    done_d = 1'b0;
    unique case (state_d)
      S_WR_HI: begin
        out_d.latch  = (op_d == OP_LATCH);
        out_d.latch3 = (op_d == OP_LATCH3);
      end
      S_WR_LO: done_d = 1'b1;
      S_RD: begin
        out_d.oe1 = (op_d == OP_RD1);
        out_d.oe2 = (op_d == OP_RD2);
        out_d.oe3 = (op_d == OP_RD3);
        done_d    = (cnt_d == 4'd0);
      end
      S_ERR: begin
        done_d    = 1'b1;
        out_d.err = 1'b1;
      end
      default: done_d = 1'b0;
    endcase
    out_d.busy   = (state_d != S_IDLE);
    out_d.gnt_a  = out_d.busy && (owner_d == OWN_A);
    out_d.gnt_b  = out_d.busy && (owner_d == OWN_B);
    out_d.done_a = done_d && (owner_d == OWN_A);
    out_d.done_b = done_d && (owner_d == OWN_B);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_A;
      op_q    <= OP_LATCH;
      cnt_q   <= 4'd0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign gntA   = out_q.gnt_a;
  assign gntB   = out_q.gnt_b;
  assign doneA  = out_q.done_a;
  assign doneB  = out_q.done_b;
  assign err    = out_q.err;
  assign latch  = out_q.latch;
  assign latch3 = out_q.latch3;
  assign oe1    = out_q.oe1;
  assign oe2    = out_q.oe2;
  assign oe3    = out_q.oe3;
  assign busy   = out_q.busy;

endmodule

// File: tb/tb_latch_arbiter.sv
// Scoreboard bench for latch_arbiter: directed transactions
// push expected output cycles; a monitor pops on activity.
module tb_latch_arbiter;

  localparam int RDC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reqA = 1'b0;
  logic       reqB = 1'b0;
  logic [2:0] opA = 3'd0;
  logic [2:0] opB = 3'd0;
  logic       gntA, gntB, doneA, doneB, err;
  logic       latch, latch3, oe1, oe2, oe3, busy;
  logic [10:0] dv;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int          c;
    logic [10:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  latch_arbiter #(.RD_CYCLES(RDC)) dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .reqA   (reqA),
    .reqB   (reqB),
    .opA    (opA),
    .opB    (opB),
    .gntA   (gntA),
    .gntB   (gntB),
    .doneA  (doneA),
    .doneB  (doneB),
    .err    (err),
    .latch  (latch),
    .latch3 (latch3),
    .oe1    (oe1),
    .oe2    (oe2),
    .oe3    (oe3),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign dv = {gntA, gntB, doneA, doneB, err,
               latch, latch3, oe1, oe2, oe3, busy};

  function automatic logic [10:0] ev(
    input bit ga, input bit gb,
    input bit da, input bit db, input bit er,
    input bit la, input bit l3,
    input bit o1, input bit o2, input bit o3
  );
    return {ga, gb, da, db, er, la, l3, o1, o2, o3, ga | gb};
  endfunction

  task automatic push(input int c, input logic [10:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    sb.push_back(e);
  endtask

  // b: 0=A 1=B; l3 selects latch3
  task automatic wr(input bit b, input bit l3, input int c);
    push(c, ev(!b, b, 0, 0, 0, !l3, l3, 0, 0, 0));
    push(c + 1, ev(!b, b, !b, b, 0, 0, 0, 0, 0, 0));
  endtask

  // w: 1=oe1 2=oe2 3=oe3
  task automatic rd(input bit b, input int w, input int c);
    for (int i = 0; i < RDC; i++) begin
      bit last;
      last = (i == RDC - 1);
      push(c + i, ev(!b, b, !b && last, b && last, 0, 0, 0,
                     w == 1, w == 2, w == 3));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [10:0] exp);
    total++;
    if (dv !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, dv, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dv !== 11'd0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out cyc=%0d got=%b required=idle",
                 cyc, dv);
      end else begin
        me = sb.pop_front();
        if (me.c != cyc || me.v !== dv) begin
          bad++;
          $display("FAIL sb_out cyc=%0d got=%b required=%b at cyc %0d",
                   cyc, dv, me.v, me.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    @(negedge clk);
    chk("reset_outs", 11'd0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    @(negedge clk);
    chk("post_reset_idle", 11'd0);
    tick(1);

    // single write A, req/op changed after grant
    c = cyc; reqA = 1; opA = 3'd0;
    wr(0, 0, c + 1);
    tick(1); reqA = 0; opA = 3'd7;
    tick(5);

    // read B oe2
    c = cyc; reqB = 1; opB = 3'd4;
    rd(1, 2, c + 1);
    tick(1); reqB = 0; opB = 3'd0;
    tick(6);

    // read A oe1, read B oe3
    c = cyc; reqA = 1; opA = 3'd2;
    rd(0, 1, c + 1);
    tick(1); reqA = 0;
    tick(6);
    c = cyc; reqB = 1; opB = 3'd3;
    rd(1, 3, c + 1);
    tick(1); reqB = 0;
    tick(6);

    // both held: A, B, A with idle gaps
    c = cyc; reqA = 1; opA = 3'd0; reqB = 1; opB = 3'd1;
    wr(0, 0, c + 1);
    wr(1, 1, c + 4);
    wr(0, 0, c + 7);
    tick(7); reqA = 0; reqB = 0;
    tick(5);

    // illegal op from A
    c = cyc; reqA = 1; opA = 3'd6;
    push(c + 1, ev(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tick(1); reqA = 0; opA = 3'd0;
    tick(4);

    // both request after A was last: B first
    c = cyc; reqA = 1; opA = 3'd2; reqB = 1; opB = 3'd2;
    rd(1, 1, c + 1);
    rd(0, 1, c + 5);
    tick(1); reqB = 0;
    tick(4); reqA = 0;
    tick(6);

    // reset during second read cycle
    c = cyc; reqA = 1; opA = 3'd3;
    push(c + 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tick(1); reqA = 0;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("reset_async_drop", 11'd0);
    @(negedge clk);
    chk("reset_no_done", 11'd0);
    tick(3);
    rst_n = 1'b1;
    tick(6);

    // both after reset: A preferred
    c = cyc; reqA = 1; opA = 3'd1; reqB = 1; opB = 3'd0;
    wr(0, 1, c + 1);
    wr(1, 0, c + 4);
    tick(1); reqA = 0;
    tick(3); reqB = 0;
    tick(6);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d pending required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
